// File: rtl/encoder_16to4_seq.sv
// rtl/encoder_16to4_seq.sv - sequential 16-to-4 encoder, one set-bit index per cycle (ENC_MSB_FIRST_EN: descending order)
module encoder_16to4_seq #(
    parameter int IN_W   = 16,
    parameter int CODE_W = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IN_W-1:0]   in,
    output logic              ready,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              zero,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [IN_W-1:0]     r_pend;
    logic [CNT_W-1:0]    r_count;
    logic                r_zero;

    logic [CODE_W-1:0]   w_idx;
    logic                w_last;
    logic                w_xfer;

    // Last match wins, so the loop direction picks which end of pend is served first.
    always_comb begin
        w_idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < IN_W; i++) begin
            if (r_pend[i]) w_idx = CODE_W'(i);
        end
`else
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (r_pend[i]) w_idx = CODE_W'(i);
        end
`endif
    end

    assign w_last = ((r_pend & (r_pend - IN_W'(1))) == '0);
    assign w_xfer = (r_state == S_SCAN) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_count <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pend  <= in;
                        r_count <= '0;
                        r_zero  <= (in == '0);
                        r_state <= (in == '0) ? S_DONE : S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_xfer) begin
                        r_pend  <= r_pend & ~(IN_W'(1) << w_idx);
                        r_count <= r_count + CNT_W'(1);
                        if (w_last) r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready      = (r_state == S_IDLE);
    assign code_valid = (r_state == S_SCAN);
    assign code       = code_valid ? w_idx : '0;
    assign done       = (r_state == S_DONE);
    assign zero       = done & r_zero;
    assign count      = r_count;

endmodule

// File: tb/tb_encoder_16to4_seq.sv
// tb/tb_encoder_16to4_seq.sv - scoreboard bench for encoder_16to4_seq (honours ENC_MSB_FIRST_EN)
module tb_encoder_16to4_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] in_v;
    logic        ready;
    logic [3:0]  code;
    logic        code_valid;
    logic        out_ready;
    logic        done;
    logic        zero;
    logic [4:0]  count;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [3:0]  exp_q[$];

    encoder_16to4_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in         (in_v),
        .ready      (ready),
        .code       (code),
        .code_valid (code_valid),
        .out_ready  (out_ready),
        .done       (done),
        .zero       (zero),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic void push_exp(input logic [15:0] v);
        for (int k = 0; k < 16; k++) begin
            int i;
`ifdef ENC_MSB_FIRST_EN
            i = 15 - k;
`else
            i = k;
`endif
            if (v[i]) exp_q.push_back(4'(i));
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic accept(input logic [15:0] v);
        in_v  = v;
        start = 1'b1;
        push_exp(v);
        @(negedge clk);
        start = 1'b0;
        in_v  = 16'hDEAD;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_v = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else n_pass++;
        n_total++; if (code_valid !== 1'b0) $display("FAIL reset_code_valid got %b want 0", code_valid); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_total++; if (code !== 4'd0) $display("FAIL reset_code got %0d want 0", code); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0] e;
        accept(16'h0001);
        e = exp_q.pop_front();
        n_total++; if (code_valid !== 1'b1 || code !== e) $display("FAIL single_code got v=%b c=%0d want v=1 c=%0d", code_valid, code, e); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b1 || zero !== 1'b0) $display("FAIL single_done got d=%b z=%b want d=1 z=0", done, zero); else n_pass++;
        n_total++; if (count !== 5'd1) $display("FAIL single_count got %0d want 1", count); else n_pass++;
        n_total++; if (code_valid !== 1'b0) $display("FAIL single_cv_in_done got %b want 0", code_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL single_ready got r=%b d=%b want r=1 d=0", ready, done); else n_pass++;
    endtask

    task automatic test_multi();
        logic [3:0] e;
        out_ready = 1'b1;
        accept(16'h8421);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_total++; if (code_valid !== 1'b1 || code !== e) $display("FAIL multi_code%0d got v=%b c=%0d want v=1 c=%0d", k, code_valid, code, e); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (done !== 1'b1 || zero !== 1'b0) $display("FAIL multi_done got d=%b z=%b want d=1 z=0", done, zero); else n_pass++;
        n_total++; if (count !== 5'd4) $display("FAIL multi_count got %0d want 4", count); else n_pass++;
        @(negedge clk);
        n_total++; if (ready !== 1'b1) $display("FAIL multi_ready got %b want 1", ready); else n_pass++;
    endtask

    task automatic test_zero();
        accept(16'h0000);
        n_total++; if (code_valid !== 1'b0) $display("FAIL zero_cv got %b want 0", code_valid); else n_pass++;
        n_total++; if (done !== 1'b1 || zero !== 1'b1) $display("FAIL zero_flags got d=%b z=%b want d=1 z=1", done, zero); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL zero_count got %0d want 0", count); else n_pass++;
        @(negedge clk);
        n_total++; if (ready !== 1'b1 || done !== 1'b0 || zero !== 1'b0) $display("FAIL zero_after got r=%b d=%b z=%b want 1 0 0", ready, done, zero); else n_pass++;
    endtask

    task automatic test_stall();
        logic [3:0] e;
        out_ready = 1'b0;
        accept(16'h0110);
        for (int k = 0; k < 3; k++) begin
            n_total++; if (code_valid !== 1'b1 || code !== exp_q[0] || count !== 5'd0)
                $display("FAIL stall_hold%0d got v=%b c=%0d n=%0d want v=1 c=%0d n=0", k, code_valid, code, count, exp_q[0]);
            else n_pass++;
            if (k == 1) begin
                start = 1'b1; in_v = 16'hFFFF;
            end else begin
                start = 1'b0; in_v = 16'hDEAD;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_total++; if (code_valid !== 1'b1 || code !== e) $display("FAIL stall_code%0d got v=%b c=%0d want v=1 c=%0d", k, code_valid, code, e); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (done !== 1'b1 || count !== 5'd2) $display("FAIL stall_done got d=%b n=%0d want d=1 n=2", done, count); else n_pass++;
        @(negedge clk);
        n_total++; if (ready !== 1'b1 || code_valid !== 1'b0) $display("FAIL stall_ignored_start got r=%b v=%b want r=1 v=0", ready, code_valid); else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [3:0] e;
        out_ready = 1'b1;
        accept(16'hFFFF);
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            n_total++; if (code_valid !== 1'b1 || code !== e) $display("FAIL abort_code%0d got v=%b c=%0d want v=1 c=%0d", k, code_valid, code, e); else n_pass++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        n_total++; if (ready !== 1'b1 || code_valid !== 1'b0 || code !== 4'd0)
            $display("FAIL abort_outputs got r=%b v=%b c=%0d want 1 0 0", ready, code_valid, code);
        else n_pass++;
        n_total++; if (done !== 1'b0 || zero !== 1'b0 || count !== 5'd0)
            $display("FAIL abort_status got d=%b z=%b n=%0d want 0 0 0", done, zero, count);
        else n_pass++;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++; if (done !== 1'b0 || ready !== 1'b1) $display("FAIL abort_nodone%0d got d=%b r=%b want d=0 r=1", k, done, ready); else n_pass++;
        end
    endtask

    task automatic test_full();
        logic [3:0] e;
        out_ready = 1'b1;
        accept(16'hFFFF);
        for (int k = 0; k < 16; k++) begin
            e = exp_q.pop_front();
            n_total++; if (code_valid !== 1'b1 || code !== e) $display("FAIL full_code%0d got v=%b c=%0d want v=1 c=%0d", k, code_valid, code, e); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (done !== 1'b1 || count !== 5'd16) $display("FAIL full_done got d=%b n=%0d want d=1 n=16", done, count); else n_pass++;
        @(negedge clk);
        n_total++; if (count !== 5'd16) $display("FAIL full_count_held got %0d want 16", count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic [3:0]  e;
        bit          seen;
        for (int t = 0; t < 8; t++) begin
            v = (t == 3) ? 16'h0000 : 16'($urandom & $urandom);
            n_total++; if (ready !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", t, ready); else n_pass++;
            accept(v);
            seen = 1'b0;
            for (int c = 0; c < 120; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                if (code_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++; $display("FAIL b2b_extra_code%0d got c=%0d want none", t, code);
                    end else begin
                        e = exp_q.pop_front();
                        n_total++; if (code !== e) $display("FAIL b2b_code%0d got %0d want %0d", t, code, e); else n_pass++;
                    end
                end
                @(negedge clk);
            end
            n_total++; if (!seen) $display("FAIL b2b_timeout%0d got no done want done", t); else n_pass++;
            n_total++; if (count !== 5'($countones(v))) $display("FAIL b2b_count%0d got %0d want %0d", t, count, $countones(v)); else n_pass++;
            n_total++; if (zero !== (v == 16'h0)) $display("FAIL b2b_zero%0d got %b want %b", t, zero, (v == 16'h0)); else n_pass++;
            n_total++; if (exp_q.size() != 0) $display("FAIL b2b_leftover%0d got %0d want 0", t, exp_q.size()); else n_pass++;
            exp_q.delete();
            @(negedge clk);
            out_ready = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_stall();
        test_reset_abort();
        test_full();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
